// File: rtl/rv32_issue_ctrl.sv
// Issue controller between decode and execute: register scoreboard, RAW/WAW
// hazard stalls, redirect/flush sequencing and a saturating stall counter.
module rv32_issue_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd,
  input  logic              id_rd_write,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              ex_redirect,
  input  logic [31:0]       ex_redirect_pc,
  output logic              issue,
  output logic              stall_fetch,
  output logic              stall_decode,
  output logic              flush_decode,
  output logic              pc_load,
  output logic [31:0]       pc_next,
  output logic [31:0]       busy_regs,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] FCNT_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_fcnt;
  logic [3:0]       w_fcnt_nxt;
  logic [31:0]      r_busy;
  logic [31:0]      w_busy_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_pend_rs1;
  logic w_pend_rs2;
  logic w_pend_rd;
  logic w_hazard;
  logic w_issue;
  logic w_stall;
  logic w_flush;
  logic w_pc_load;

  // A writeback landing this cycle is already visible (write-through regfile).
  assign w_pend_rs1 = (id_rs1 != 5'd0) & r_busy[id_rs1] & ~(wb_valid & (wb_rd == id_rs1));
  assign w_pend_rs2 = (id_rs2 != 5'd0) & r_busy[id_rs2] & ~(wb_valid & (wb_rd == id_rs2));
  assign w_pend_rd  = (id_rd  != 5'd0) & r_busy[id_rd]  & ~(wb_valid & (wb_rd == id_rd));
  assign w_hazard   = id_valid & ((id_rs1_used & w_pend_rs1) |
                                  (id_rs2_used & w_pend_rs2) |
                                  (id_rd_write & w_pend_rd));

  // Next-state and control outputs; a redirect always beats a hazard stall.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_issue     = 1'b0;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_pc_load   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (ex_redirect) begin
          w_pc_load = 1'b1;
          w_flush   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = S_FLUSH;
            w_fcnt_nxt  = FCNT_RELOAD;
          end else begin
            w_fcnt_nxt  = 4'd0;
          end
        end else if (w_hazard) begin
          w_stall = 1'b1;
        end else begin
          w_issue = id_valid;
        end
      end
      S_FLUSH: begin
        w_flush = 1'b1;
        if (ex_redirect) begin
          w_pc_load  = 1'b1;
          w_fcnt_nxt = FCNT_RELOAD;
        end else if (r_fcnt <= 4'd1) begin
          w_state_nxt = S_RUN;
          w_fcnt_nxt  = 4'd0;
        end else begin
          w_fcnt_nxt  = r_fcnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_fcnt_nxt  = 4'd0;
      end
    endcase
    if (!resetn) begin
      w_issue   = 1'b0;
      w_stall   = 1'b0;
      w_flush   = 1'b0;
      w_pc_load = 1'b0;
    end else begin
      w_issue   = w_issue;
    end
  end

  // Scoreboard next value: clear first so a same-register set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) begin
      w_busy_nxt[wb_rd] = 1'b0;
    end else begin
      w_busy_nxt = w_busy_nxt;
    end
    if (w_issue && id_rd_write && (id_rd != 5'd0)) begin
      w_busy_nxt[id_rd] = 1'b1;
    end else begin
      w_busy_nxt = w_busy_nxt;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // State, scoreboard and saturating stall counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_RUN;
      r_fcnt      <= 4'd0;
      r_busy      <= 32'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_busy  <= w_busy_nxt;
      if (w_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign issue        = w_issue;
  assign stall_fetch  = w_stall;
  assign stall_decode = w_stall;
  assign flush_decode = w_flush;
  assign pc_load      = w_pc_load;
  assign pc_next      = ex_redirect_pc;
  assign busy_regs    = r_busy;
  assign stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_rv32_issue_ctrl.sv
// Scoreboard bench for rv32_issue_ctrl: directed scenarios plus random traffic
// checked against a set-of-pending-registers reference model.
module tb_rv32_issue_ctrl;
  localparam int FC    = 2;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic resetn, id_valid, id_rs1_used, id_rs2_used, id_rd_write, wb_valid, ex_redirect;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic [31:0] ex_redirect_pc;
  logic issue, stall_fetch, stall_decode, flush_decode, pc_load;
  logic [31:0] pc_next, busy_regs;
  logic [CNT_W-1:0] stall_count;

  rv32_issue_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_write(id_rd_write), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc), .issue(issue),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .flush_decode(flush_decode),
    .pc_load(pc_load), .pc_next(pc_next), .busy_regs(busy_regs), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             issue;
    logic             stall_f;
    logic             stall_d;
    logic             flush;
    logic             pc_load;
    logic [31:0]      pc_next;
    logic [31:0]      busy;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  // Reference model: set of pending destinations, remaining flush cycles, stall tally.
  bit   m_busy[32];
  int   m_flush_left;
  int   m_cnt;

  function automatic bit pend(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(wb_valid && wb_rd == r);
  endfunction

  task automatic cyc();
    exp_t e;
    bit   haz;
    e = '0;
    for (int i = 0; i < 32; i++) e.busy[i] = m_busy[i];
    e.cnt     = CNT_W'(m_cnt);
    e.pc_next = ex_redirect_pc;
    if (!resetn) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_cnt = 0;
      m_flush_left = 0;
    end else begin
      haz = id_valid && ((id_rs1_used && pend(id_rs1)) || (id_rs2_used && pend(id_rs2)) ||
                         (id_rd_write && pend(id_rd)));
      if (ex_redirect) begin
        e.pc_load = 1'b1;
        e.flush = 1'b1;
        m_flush_left = FC - 1;
      end else if (m_flush_left > 0) begin
        e.flush = 1'b1;
        m_flush_left--;
      end else if (haz) begin
        e.stall_f = 1'b1;
        e.stall_d = 1'b1;
        if (m_cnt < CMAX) m_cnt++;
      end else begin
        e.issue = id_valid;
      end
      if (wb_valid) m_busy[wb_rd] = 1'b0;
      if (e.issue && id_rd_write && id_rd != 5'd0) m_busy[id_rd] = 1'b1;
    end
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic clr();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_write = 0; wb_valid = 0; wb_rd = 0; ex_redirect = 0;
    ex_redirect_pc = 32'h0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rd,
                        input logic w);
    id_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = 5'd0; id_rs2_used = 0;
    id_rd = rd; id_rd_write = w;
  endtask

  // Monitor: one comparison per cycle of every output against the queued expectation.
  always @(negedge clk) begin
    exp_t e, a;
    cyc_no++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {issue, stall_fetch, stall_decode, flush_decode, pc_load, pc_next, busy_regs, stall_count};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t: got iss=%b sf=%b sd=%b fl=%b pl=%b pc=%h busy=%h cnt=%0d, want iss=%b sf=%b sd=%b fl=%b pl=%b pc=%h busy=%h cnt=%0d",
                 $time, a.issue, a.stall_f, a.stall_d, a.flush, a.pc_load, a.pc_next, a.busy, a.cnt,
                 e.issue, e.stall_f, e.stall_d, e.flush, e.pc_load, e.pc_next, e.busy, e.cnt);
      end
    end
  end

  initial begin
    clr();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc();                                   // reset state
    resetn = 1;

    // back-to-back dependency, resolved by same-cycle writeback
    set_id(5'd1, 1'b1, 5'd5, 1'b1); cyc();
    set_id(5'd5, 1'b1, 5'd6, 1'b1); cyc(); cyc(); cyc();
    wb_valid = 1; wb_rd = 5'd5; cyc();
    clr(); cyc();
    wb_valid = 1; wb_rd = 5'd6; cyc();
    clr();

    // x0 never becomes busy and never stalls
    set_id(5'd0, 1'b0, 5'd0, 1'b1); cyc();
    set_id(5'd0, 1'b1, 5'd0, 1'b0); cyc();

    // WAW stall, then issue alongside writeback of the same register: set wins
    set_id(5'd0, 1'b0, 5'd7, 1'b1); cyc();
    cyc(); cyc();
    wb_valid = 1; wb_rd = 5'd7; cyc();
    clr(); cyc();
    wb_valid = 1; wb_rd = 5'd7; cyc();
    clr();

    // plain redirect
    ex_redirect = 1; ex_redirect_pc = 32'h100; set_id(5'd0, 1'b0, 5'd3, 1'b1); cyc();
    ex_redirect = 0; cyc(); cyc(); cyc();
    clr();

    // redirect during a stall, then a second redirect inside the flush
    set_id(5'd0, 1'b0, 5'd9, 1'b1); cyc();
    set_id(5'd9, 1'b1, 5'd0, 1'b0); cyc(); cyc();
    ex_redirect = 1; ex_redirect_pc = 32'h180; cyc();
    ex_redirect = 1; ex_redirect_pc = 32'h200; cyc();
    ex_redirect = 0; cyc(); cyc(); cyc();
    clr(); wb_valid = 1; wb_rd = 5'd9; cyc();
    clr();

    // reset in the middle of a flush with x5 and x7 pending
    set_id(5'd0, 1'b0, 5'd5, 1'b1); cyc();
    set_id(5'd0, 1'b0, 5'd7, 1'b1); cyc();
    clr(); ex_redirect = 1; ex_redirect_pc = 32'h300; cyc();
    clr(); resetn = 0; ex_redirect_pc = 32'h44; cyc();
    resetn = 1; cyc(); cyc();

    // long stall drives the counter into saturation
    set_id(5'd0, 1'b0, 5'd3, 1'b1); cyc();
    set_id(5'd3, 1'b1, 5'd0, 1'b0);
    repeat (CMAX + 6) cyc();
    wb_valid = 1; wb_rd = 5'd3; cyc();
    clr(); resetn = 0; cyc();
    resetn = 1;

    // random traffic on a small register window to provoke hazards
    repeat (2000) begin
      resetn         = ($urandom_range(0, 99) != 0);
      id_valid       = ($urandom_range(0, 3) != 0);
      id_rs1         = 5'($urandom_range(0, 7));
      id_rs2         = 5'($urandom_range(0, 7));
      id_rs1_used    = $urandom_range(0, 1) == 1;
      id_rs2_used    = $urandom_range(0, 1) == 1;
      id_rd          = 5'($urandom_range(0, 7));
      id_rd_write    = $urandom_range(0, 2) != 0;
      wb_valid       = $urandom_range(0, 2) == 0;
      wb_rd          = 5'($urandom_range(0, 7));
      ex_redirect    = $urandom_range(0, 11) == 0;
      ex_redirect_pc = $urandom;
      cyc();
    end
    clr();

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
